soc_system_uart_status_in: RTL and testbench
============================================

// Module: soc_system_uart_status_in
// PURPOSE
// - Avalon-MM slave input port with edge capture and interrupt. It is the read-side counterpart of the
//   UART flag output register: it samples UART status lines (e.g. rx_ready, tx_busy, error) from fabric.
// - It synchronises and debounces the lines and latches edges. It raises irq to the HPS when an unmasked
//   edge is latched.
// PARAMETERS
// - WIDTH            4   number of input status lines (1..32)
// - EDGE_TYPE        0   0 = rising, 1 = falling, 2 = any edge sets edgecapture
// - DEBOUNCE_CYCLES  16  consecutive stable cycles required before accepting a change; 0 = bypass
// - RESET_MASK       0   reset value of irqmask[WIDTH-1:0]
// PORTS
// - clk         in   1      system clock
// - reset_n     in   1      asynchronous, active-low reset
// - address     in   3      Avalon word address
// - chipselect  in   1      Avalon select
// - read_n      in   1      active-low read strobe
// - write_n     in   1      active-low write strobe
// - writedata   in   32     write data
// - in_port     in   WIDTH  asynchronous status lines
// - readdata    out  32     read data, registered, 1-cycle latency
// - irq         out  1      level interrupt = |(edgecapture & irqmask)
// BEHAVIOUR
// - Reset (async): sync flops, stable, prev, edgecapture, debounce counters and readdata are 0;
//   irqmask = RESET_MASK; irq = 0.
// - Synchroniser: in_port passes through a 2-flop chain into sync[WIDTH-1:0]. There is no other use
//   of raw in_port.
// - Debounce, per bit, with counter width clog2(DEBOUNCE_CYCLES+1):
//   - If sync == stable: the counter clears.
//   - Otherwise the counter increments. When the counter reaches DEBOUNCE_CYCLES-1 and the bit still
//     differs, stable <= sync and the counter clears.
//   - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
//   - If DEBOUNCE_CYCLES = 0, stable is sync combinationally.
// - Edge detect: prev <= stable every cycle.
//   - rise = stable & ~prev; fall = ~stable & prev; the edge vector is selected by EDGE_TYPE.
// - Latency: with DEBOUNCE_CYCLES = 0, an in_port change set up before clock edge k appears in
//   edgecapture after edge k+2. Each debounce cycle adds one edge.
// - Line high at reset: because stable resets to 0, the line is captured as a rising edge once it is
//   accepted. This is intended.
// - Register map (word address). Upper bits beyond WIDTH read 0; unused addresses read 0.
//   - 0  data         RO  stable[WIDTH-1:0]; writes ignored
//   - 2  irqmask      RW  writedata[WIDTH-1:0]
//   - 3  edgecapture  RW1C  writing 1 to a bit clears it; writing 0 leaves it unchanged
//   - 1, 4-7  reserved; reads return 0 and writes are ignored
// - Write strobe = chipselect & ~write_n. The write takes effect at the next clock edge.
// - Edgecapture bit update, in priority order per bit:
//   - A new edge in the same cycle as a clear: the bit is set. Set wins, so no event is lost.
//   - Clear only: the bit goes to 0.
//   - Otherwise the bit holds.
// - Read strobe = chipselect & ~read_n.
//   - On the next edge, readdata <= mux(address) using pre-update register values.
//   - readdata holds its value when there is no read strobe.
//   - A read and write in the same cycle to the same address returns the old value.
// - irq is combinational from the edgecapture and irqmask registers. There is no extra pipeline stage
//   and no glitch path from in_port.
// - Reset mid-debounce or with irq asserted: everything returns to its reset values immediately.
//   Pending edges are discarded.
// TESTING
// - Reset, then read each address with in_port=0 -> readdata = 0x0 at addresses 0, 2, 3, 5;
//   irqmask reads RESET_MASK; irq=0.
// - Debounce: DEBOUNCE_CYCLES=16, a 10-cycle high pulse on in_port[1] -> data stays 0x0 and
//   edgecapture stays 0.
// - Debounce accept: a 40-cycle high on in_port[1] -> data=0x2 exactly 2+16 cycles later and
//   edgecapture=0x2. Write irqmask=0x2 -> irq=1 the next cycle.
// - RW1C: edgecapture=0xA; write 0x8 to address 3 -> edgecapture=0x2. irq follows the mask.
//   Write 0x0 -> no change.
// - Simultaneous event: a rising edge on bit 0 in the same cycle as a write of 0x1 to address 3 ->
//   bit 0 remains 1.
// - EDGE_TYPE=1 with DEBOUNCE_CYCLES=0: a 1->0 transition on in_port[3] -> edgecapture[3]=1 after
//   3 clock edges. A 0->1 transition does not set it.

Source files
------------

// File: rtl/soc_system_uart_status_in.sv
// Avalon-MM status input port for UART flag lines: synchroniser, per-bit debounce,
// edge capture (RW1C) and a maskable level interrupt.
module soc_system_uart_status_in #(
  parameter int              WIDTH           = 4,
  parameter int              EDGE_TYPE       = 0,
  parameter int              DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_MASK     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_v;
  logic [WIDTH-1:0] clear_v;
  logic [31:0]      rd_mux;
  logic             wr_stb;
  logic             rd_stb;
  logic             unused_bits;

  assign unused_bits = ^{writedata, 1'b0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= in_port;
      sync      <= sync_meta;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign stable = sync;
    end else begin : g_debounce
      logic [CW-1:0] cnt [WIDTH];

      // A bit is accepted only after it has differed from stable for DEBOUNCE_CYCLES edges.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          stable <= '0;
          for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] == stable[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
              stable[i] <= sync[i];
              cnt[i]    <= '0;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
        end
      end
    end
  endgenerate

  assign rise = stable & ~prev;
  assign fall = ~stable & prev;

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_v = rise;
      1:       edge_v = fall;
      default: edge_v = rise | fall;
    endcase
  end

  assign wr_stb  = chipselect & ~write_n;
  assign rd_stb  = chipselect & ~read_n;
  assign clear_v = (wr_stb && address == 3'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux[WIDTH-1:0] = stable;
      3'd2:    rd_mux[WIDTH-1:0] = irqmask;
      3'd3:    rd_mux[WIDTH-1:0] = edgecapture;
      default: rd_mux = '0;
    endcase
  end

  // New edges are OR'd in after the clear so an event coinciding with a clear is kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev        <= '0;
      edgecapture <= '0;
      irqmask     <= RESET_MASK;
      readdata    <= '0;
    end else begin
      prev        <= stable;
      edgecapture <= (edgecapture & ~clear_v) | edge_v;
      if (wr_stb && address == 3'd2) irqmask <= writedata[WIDTH-1:0];
      if (rd_stb) readdata <= rd_mux;
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_soc_system_uart_status_in.sv
// Directed bench: instance a uses default parameters, instance b is falling-edge,
// no debounce, non-zero reset mask. Both share the bus.
module tb_soc_system_uart_status_in;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_a = '0;
  logic [3:0]  in_b = '0;
  logic [31:0] readdata_a;
  logic [31:0] readdata_b;
  logic        irq_a;
  logic        irq_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  soc_system_uart_status_in dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_a),
    .readdata(readdata_a), .irq(irq_a)
  );

  soc_system_uart_status_in #(
    .WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(0), .RESET_MASK(4'h5)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_b),
    .readdata(readdata_b), .irq(irq_b)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] ra, output logic [31:0] rb);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(posedge clk); #1;
    ra = readdata_a; rb = readdata_b;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] ra, rb;
    logic [2:0]  addrs [4];
    logic [31:0] exp_b [4];
    addrs = '{3'd0, 3'd2, 3'd3, 3'd5};
    exp_b = '{32'h0, 32'h5, 32'h0, 32'h0};
    reset_n = 1'b0; in_a = '0; in_b = '0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    checks++;
    if (irq_a !== 1'b0) begin failures++; $display("FAIL reset_irq_a got=%b exp=0", irq_a); end
    checks++;
    if (irq_b !== 1'b0) begin failures++; $display("FAIL reset_irq_b got=%b exp=0", irq_b); end
    for (int i = 0; i < 4; i++) begin
      bus_read(addrs[i], ra, rb);
      checks++;
      if (ra !== 32'h0) begin
        failures++; $display("FAIL reset_read_a addr=%0d got=%h exp=0", addrs[i], ra);
      end
      checks++;
      if (rb !== exp_b[i]) begin
        failures++; $display("FAIL reset_read_b addr=%0d got=%h exp=%h", addrs[i], rb, exp_b[i]);
      end
    end
  endtask

  task automatic test_debounce_glitch;
    logic [31:0] ra, rb;
    in_a = 4'h2;
    tick(10);
    in_a = 4'h0;
    tick(30);
    bus_read(3'd0, ra, rb);
    checks++;
    if (ra !== 32'h0) begin failures++; $display("FAIL glitch_data got=%h exp=0", ra); end
    bus_read(3'd3, ra, rb);
    checks++;
    if (ra !== 32'h0) begin failures++; $display("FAIL glitch_edgecapture got=%h exp=0", ra); end
  endtask

  task automatic test_debounce_accept;
    logic [31:0] ra, rb;
    logic [31:0] exp;
    in_a = 4'h2;
    address = 3'd0; chipselect = 1'b1; read_n = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      exp = (n >= 18) ? 32'h2 : 32'h0;
      checks++;
      if (readdata_a !== exp) begin
        failures++; $display("FAIL accept_data edge=k+%0d got=%h exp=%h", n, readdata_a, exp);
      end
    end
    chipselect = 1'b0; read_n = 1'b1;
    tick(20);
    in_a = 4'h0;
    bus_read(3'd3, ra, rb);
    checks++;
    if (ra !== 32'h2) begin failures++; $display("FAIL accept_edgecapture got=%h exp=2", ra); end
    checks++;
    if (irq_a !== 1'b0) begin failures++; $display("FAIL accept_irq_masked got=%b exp=0", irq_a); end
    bus_write(3'd2, 32'h2);
    checks++;
    if (irq_a !== 1'b1) begin failures++; $display("FAIL accept_irq_unmasked got=%b exp=1", irq_a); end
    tick(25);
  endtask

  task automatic test_rw1c;
    logic [31:0] ra, rb;
    in_a = 4'h8;
    tick(20);
    in_a = 4'h0;
    tick(25);
    bus_read(3'd3, ra, rb);
    checks++;
    if (ra !== 32'hA) begin failures++; $display("FAIL rw1c_initial got=%h exp=a", ra); end
    checks++;
    if (irq_a !== 1'b1) begin failures++; $display("FAIL rw1c_irq_initial got=%b exp=1", irq_a); end
    bus_write(3'd3, 32'h8);
    bus_read(3'd3, ra, rb);
    checks++;
    if (ra !== 32'h2) begin failures++; $display("FAIL rw1c_clear8 got=%h exp=2", ra); end
    checks++;
    if (irq_a !== 1'b1) begin failures++; $display("FAIL rw1c_irq_after_clear8 got=%b exp=1", irq_a); end
    bus_write(3'd3, 32'h0);
    bus_read(3'd3, ra, rb);
    checks++;
    if (ra !== 32'h2) begin failures++; $display("FAIL rw1c_write0 got=%h exp=2", ra); end
    bus_write(3'd2, 32'h8);
    checks++;
    if (irq_a !== 1'b0) begin failures++; $display("FAIL rw1c_irq_mask8 got=%b exp=0", irq_a); end
    bus_write(3'd2, 32'h2);
    bus_write(3'd3, 32'h2);
    bus_read(3'd3, ra, rb);
    checks++;
    if (ra !== 32'h0) begin failures++; $display("FAIL rw1c_clear2 got=%h exp=0", ra); end
    checks++;
    if (irq_a !== 1'b0) begin failures++; $display("FAIL rw1c_irq_cleared got=%b exp=0", irq_a); end
  endtask

  task automatic test_simultaneous;
    logic [31:0] ra, rb;
    in_a = 4'h1;
    @(posedge clk);
    repeat (17) @(posedge clk);
    #1;
    // Edge k+18 both latches the rising edge on bit 0 and applies the clear.
    address = 3'd3; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0; read_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    checks++;
    if (readdata_a !== 32'h0) begin failures++; $display("FAIL simul_read_old got=%h exp=0", readdata_a); end
    bus_read(3'd3, ra, rb);
    checks++;
    if (ra !== 32'h1) begin failures++; $display("FAIL simul_set_wins got=%h exp=1", ra); end
    in_a = 4'h0;
    tick(25);
    bus_write(3'd3, 32'h1);
    address = 3'd2; writedata = 32'h5; chipselect = 1'b1; write_n = 1'b0; read_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    checks++;
    if (readdata_a !== 32'h2) begin failures++; $display("FAIL rw_same_addr_old got=%h exp=2", readdata_a); end
    bus_read(3'd2, ra, rb);
    checks++;
    if (ra !== 32'h5) begin failures++; $display("FAIL rw_same_addr_new got=%h exp=5", ra); end
  endtask

  task automatic test_edge_fall;
    logic [31:0] ra, rb;
    bus_write(3'd2, 32'h8);
    in_b = 4'h8;
    tick(5);
    checks++;
    if (irq_b !== 1'b0) begin failures++; $display("FAIL fall_rise_irq got=%b exp=0", irq_b); end
    bus_read(3'd3, ra, rb);
    checks++;
    if (rb !== 32'h0) begin failures++; $display("FAIL fall_rise_edgecapture got=%h exp=0", rb); end
    in_b = 4'h0;
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (irq_b !== 1'b0) begin failures++; $display("FAIL fall_early_irq got=%b exp=0", irq_b); end
    @(posedge clk); #1;
    checks++;
    if (irq_b !== 1'b1) begin failures++; $display("FAIL fall_irq got=%b exp=1", irq_b); end
    bus_read(3'd3, ra, rb);
    checks++;
    if (rb !== 32'h8) begin failures++; $display("FAIL fall_edgecapture got=%h exp=8", rb); end
  endtask

  task automatic test_reset_midway;
    logic [31:0] ra, rb;
    in_a = 4'h2;
    tick(5);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (irq_b !== 1'b0) begin failures++; $display("FAIL midreset_irq_b got=%b exp=0", irq_b); end
    in_a = 4'h0; in_b = 4'h0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    bus_read(3'd3, ra, rb);
    checks++;
    if (ra !== 32'h0) begin failures++; $display("FAIL midreset_ec_a got=%h exp=0", ra); end
    checks++;
    if (rb !== 32'h0) begin failures++; $display("FAIL midreset_ec_b got=%h exp=0", rb); end
    bus_read(3'd2, ra, rb);
    checks++;
    if (ra !== 32'h0) begin failures++; $display("FAIL midreset_mask_a got=%h exp=0", ra); end
    checks++;
    if (rb !== 32'h5) begin failures++; $display("FAIL midreset_mask_b got=%h exp=5", rb); end
    tick(20);
    bus_read(3'd0, ra, rb);
    checks++;
    if (ra !== 32'h0) begin failures++; $display("FAIL midreset_data_a got=%h exp=0", ra); end
  endtask

  initial begin
    test_reset();
    test_debounce_glitch();
    test_debounce_accept();
    test_rw1c();
    test_simultaneous();
    test_edge_fall();
    test_reset_midway();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
